// File: rtl/uart_rx_buffered.sv
// rtl/uart_rx_buffered.sv - 16x-oversampling UART receiver feeding a first-word fall-through FIFO
// Default frame is 8N1; defining UART_RX_PARITY_EN switches to 8E1 with parity checking.
module uart_rx_buffered #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_50m,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [7:0]                    dout,
  output logic                          rdy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err
);

  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  state_t         state_q;
  logic           rx_meta_q, rx_sync_q, rx_prev_q;
  logic [DW-1:0]  div_q;
  logic [3:0]     sub_q;
  logic [2:0]     bit_q;
  logic [7:0]     shift_q;
  logic           push_q;
  logic           frame_err_q, overrun_q;
  logic [AW-1:0]  wr_q, rd_q;
  logic [AW:0]    count_q, count_d;
  logic [7:0]     mem [FIFO_DEPTH];
  logic           tick, start_edge, pop, full, wr_ok;
`ifdef UART_RX_PARITY_EN
  logic           par_bad_q, parity_err_q;
`endif

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign start_edge = (state_q == IDLE) && rx_prev_q && !rx_sync_q;
  assign tick       = (div_q == DW'(DIV - 1));

  // Restarting the divider at the start edge keeps bit midpoints aligned to this frame.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst)                      div_q <= '0;
    else if (start_edge || tick)  div_q <= '0;
    else                          div_q <= div_q + DW'(1);
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sub_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      push_q <= 1'b0;
      if (err_clr) begin
        frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_q <= 1'b0;
`endif
      end
      case (state_q)
        IDLE: if (start_edge) begin
          state_q <= START;
          sub_q   <= '0;
        end
        START: if (tick) begin
          sub_q <= sub_q + 4'd1;
          if (sub_q == 4'd7) begin
            sub_q   <= '0;
            bit_q   <= '0;
            state_q <= rx_sync_q ? IDLE : DATA;
          end
        end
        DATA: if (tick) begin
          sub_q <= sub_q + 4'd1;
          if (sub_q == 4'd15) begin
            shift_q <= {rx_sync_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_q == 3'd7) state_q <= PARITY;
`else
            if (bit_q == 3'd7) state_q <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (tick) begin
          sub_q <= sub_q + 4'd1;
          if (sub_q == 4'd15) begin
            par_bad_q <= ^{shift_q, rx_sync_q};
            if (^{shift_q, rx_sync_q}) parity_err_q <= 1'b1;
            state_q <= STOP;
          end
        end
`endif
        STOP: if (tick) begin
          sub_q <= sub_q + 4'd1;
          if (sub_q == 4'd15) begin
            if (rx_sync_q) begin
`ifdef UART_RX_PARITY_EN
              push_q <= !par_bad_q;
`else
              push_q <= 1'b1;
`endif
              state_q <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: if (rx_sync_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pop   = rd_en && rdy;
  assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign wr_ok = push_q && (!full || pop);

  always_comb begin
    count_d = count_q;
    if (wr_ok && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!wr_ok && pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_50m) begin
    if (wr_ok) mem[wr_q] <= shift_q;
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (wr_ok) wr_q <= wr_q + AW'(1);
      if (pop)   rd_q <= rd_q + AW'(1);
      if (err_clr) overrun_q <= 1'b0;
      if (push_q && full && !pop) overrun_q <= 1'b1;
    end
  end

  assign rdy        = (count_q != '0);
  assign dout       = rdy ? mem[rd_q] : 8'h00;
  assign fifo_level = count_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb/tb_uart_rx_buffered.sv - directed scoreboard bench for uart_rx_buffered
module tb_uart_rx_buffered;
  localparam int BIT_CLKS = 432;

  logic       clk_50m = 1'b0;
  logic       rst = 1'b1, rx = 1'b1, rd_en = 1'b0, err_clr = 1'b0;
  logic [7:0] dout;
  logic       rdy, frame_err, overrun, parity_err;
  logic [3:0] fifo_level;
  int         n_pass = 0, n_fail = 0, n_total = 0;
  logic [7:0] sb[$];

  always #10 clk_50m = ~clk_50m;

  uart_rx_buffered dut (
    .clk_50m(clk_50m), .rst(rst), .rx(rx), .rd_en(rd_en), .err_clr(err_clr),
    .dout(dout), .rdy(rdy), .fifo_level(fifo_level), .frame_err(frame_err),
    .overrun(overrun), .parity_err(parity_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clks(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop_b);
    rx = 1'b1;
    wait_clks(20);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
    chk({tag, "_rdy"}, 32'(rdy), 32'd1);
    chk(tag, 32'(dout), 32'(e));
    rd_en = 1'b1;
    wait_clks(1);
    rd_en = 1'b0;
    wait_clks(1);
  endtask

  task automatic check_flags(input string tag, input logic fe, input logic ov);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'(fe));
    chk({tag, "_overrun"}, 32'(overrun), 32'(ov));
    chk({tag, "_parity_err"}, 32'(parity_err), 32'd0);
  endtask

  initial begin
    wait_clks(5);
    chk("rst_rdy", 32'(rdy), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_dout", 32'(dout), 32'h00);
    check_flags("rst", 1'b0, 1'b0);
    rst = 1'b0;
    wait_clks(5);
    chk("post_rst_rdy", 32'(rdy), 32'd0);

    rd_en = 1'b1;
    wait_clks(1);
    rd_en = 1'b0;
    chk("empty_pop_level", 32'(fifo_level), 32'd0);

    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    chk("a5_level", 32'(fifo_level), 32'd1);
    pop_check("a5_dout");
    chk("a5_rdy_after_pop", 32'(rdy), 32'd0);

    rx = 1'b0;
    wait_clks(100);
    rx = 1'b1;
    wait_clks(600);
    chk("glitch_level", 32'(fifo_level), 32'd0);
    check_flags("glitch", 1'b0, 1'b0);
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    chk("after_glitch_level", 32'(fifo_level), 32'd1);
    pop_check("after_glitch_dout");

    send_frame(8'h3C, 1'b0);
    chk("ferr_level", 32'(fifo_level), 32'd0);
    check_flags("ferr", 1'b1, 1'b0);
    err_clr = 1'b1;
    wait_clks(1);
    err_clr = 1'b0;
    wait_clks(1);
    chk("ferr_cleared", 32'(frame_err), 32'd0);

    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) sb.push_back(8'(i));
      send_frame(8'(i), 1'b1);
    end
    chk("ovr_level", 32'(fifo_level), 32'd8);
    check_flags("ovr", 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) pop_check($sformatf("ovr_read%0d", i));
    chk("ovr_drained_rdy", 32'(rdy), 32'd0);
    err_clr = 1'b1;
    wait_clks(1);
    err_clr = 1'b0;
    wait_clks(1);
    chk("ovr_cleared", 32'(overrun), 32'd0);

    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    wait_clks(100);
    rst = 1'b1;
    wait_clks(3);
    chk("midrst_rdy", 32'(rdy), 32'd0);
    rst = 1'b0;
    wait_clks(BIT_CLKS * 6);
    chk("midrst_level", 32'(fifo_level), 32'd0);
    check_flags("midrst", 1'b0, 1'b0);
    sb.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    chk("midrst_12_level", 32'(fifo_level), 32'd1);
    pop_check("midrst_12_dout");

`ifdef UART_RX_PARITY_EN
    sb.push_back(8'h07);
    send_frame(8'h07, 1'b1);
    chk("par_good_level", 32'(fifo_level), 32'd1);
    pop_check("par_good_dout");
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i < 3);
    send_bit(1'b0);
    send_bit(1'b1);
    wait_clks(20);
    chk("par_bad_level", 32'(fifo_level), 32'd0);
    chk("par_bad_flag", 32'(parity_err), 32'd1);
`endif

    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
